// File: rtl/lsu_pkg.sv
// lsu_pkg: address map, access-size encodings and lane helpers for the load-store unit
package lsu_pkg;
  localparam logic [15:0] DMEM_BASE = 16'h2000;
  localparam logic [15:0] IO_LEDR   = 16'h7000;
  localparam logic [15:0] IO_LEDG   = 16'h7010;
  localparam logic [15:0] IO_HEX_LO = 16'h7020;
  localparam logic [15:0] IO_HEX_HI = 16'h7024;
  localparam logic [15:0] IO_LCD    = 16'h7030;
  localparam logic [15:0] IO_SW     = 16'h7800;
  localparam logic [15:0] IO_BTN    = 16'h7810;
  localparam logic [3:0] SZ_BYTE = 4'b0001;
  localparam logic [3:0] SZ_HALF = 4'b0011;
  localparam logic [3:0] SZ_WORD = 4'b1111;
  function automatic logic [3:0] lane_mask(input logic [3:0] n, input logic [1:0] off);
    return 4'(n << off);
  endfunction
  function automatic logic misaligned(input logic [3:0] n, input logic [1:0] off);
    return (n == SZ_HALF) ? off[0] : (n == SZ_WORD) ? |off : (n != SZ_BYTE);
  endfunction
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i+:8] = wd[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/lsu_if.sv
// lsu_if: core-side memory access bus of the load-store unit
interface lsu_if;
  logic [31:0] addr;
  logic [31:0] st_data;
  logic        st_en;
  logic [3:0]  byte_num;
  logic        ld_unsigned;
  logic [31:0] ld_data;
  logic        misalign;
  modport master(output addr, st_data, st_en, byte_num, ld_unsigned, input ld_data, misalign);
  modport slave(input addr, st_data, st_en, byte_num, ld_unsigned, output ld_data, misalign);
endinterface

// File: rtl/lsu_dmem.sv
// lsu_dmem: word RAM with per-byte write enables, async read, sync write
module lsu_dmem #(
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [2**AW];
  // byte-lane write on the rising edge; contents are never reset
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++) if (we && be[i]) mem[addr][8*i+:8] <= wdata[8*i+:8];
  assign rdata = mem[addr];
endmodule

// File: rtl/lsu.sv
// lsu: address decode, memory-mapped I/O registers, input synchronisers and load extraction
module lsu
  import lsu_pkg::*;
#(
  parameter int DMEM_AW     = 11,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  lsu_if.slave        bus,
  input  logic [31:0] io_sw_i,
  input  logic [3:0]  io_btn_i,
  output logic [31:0] io_ledr_o,
  output logic [31:0] io_ledg_o,
  output logic [63:0] io_hex_o,
  output logic [31:0] io_lcd_o
);
  logic [1:0]  off;
  logic [15:0] wa;
  logic        hi_ok, sel_dmem, sel_ledr, sel_ledg, sel_hlo, sel_hhi, sel_lcd, sel_sw, sel_btn;
  logic [3:0]  mask;
  logic [31:0] wdata, dmem_rdata, rdata, shifted;
  logic        wr, valid;
  logic [SYNC_STAGES-1:0][31:0] sw_sync;
  logic [SYNC_STAGES-1:0][3:0]  btn_sync;
  assign off      = bus.addr[1:0];
  assign wa       = {bus.addr[15:2], 2'b00};
  assign hi_ok    = bus.addr[31:16] == '0;
  assign sel_dmem = hi_ok && wa[15:13] == DMEM_BASE[15:13];
  assign sel_ledr = hi_ok && wa == IO_LEDR;
  assign sel_ledg = hi_ok && wa == IO_LEDG;
  assign sel_hlo  = hi_ok && wa == IO_HEX_LO;
  assign sel_hhi  = hi_ok && wa == IO_HEX_HI;
  assign sel_lcd  = hi_ok && wa == IO_LCD;
  assign sel_sw   = hi_ok && wa == IO_SW;
  assign sel_btn  = hi_ok && wa == IO_BTN;
  assign mask         = lane_mask(bus.byte_num, off);
  assign wdata        = bus.st_data << {off, 3'b000};
  assign bus.misalign = misaligned(bus.byte_num, off);
  assign wr           = bus.st_en && !bus.misalign && rst_ni;
  lsu_dmem #(.AW(DMEM_AW)) u_dmem (
    .clk  (clk_i),
    .we   (wr && sel_dmem),
    .be   (mask),
    .addr (bus.addr[DMEM_AW+1:2]),
    .wdata(wdata),
    .rdata(dmem_rdata)
  );
  // writable I/O registers and the switch/button synchroniser chains
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      io_ledr_o <= '0;
      io_ledg_o <= '0;
      io_hex_o  <= '0;
      io_lcd_o  <= '0;
      sw_sync   <= '0;
      btn_sync  <= '0;
    end else begin
      sw_sync  <= {sw_sync[SYNC_STAGES-2:0], io_sw_i};
      btn_sync <= {btn_sync[SYNC_STAGES-2:0], io_btn_i};
      if (wr && sel_ledr) io_ledr_o <= merge(io_ledr_o, wdata, mask);
      if (wr && sel_ledg) io_ledg_o <= merge(io_ledg_o, wdata, mask);
      if (wr && sel_hlo) io_hex_o[31:0] <= merge(io_hex_o[31:0], wdata, mask);
      if (wr && sel_hhi) io_hex_o[63:32] <= merge(io_hex_o[63:32], wdata, mask);
      if (wr && sel_lcd) io_lcd_o <= merge(io_lcd_o, wdata, mask);
    end
  end
  // word select, lane shift, then size truncation with sign/zero extension
  always_comb begin
    rdata = sel_dmem ? dmem_rdata : sel_ledr ? io_ledr_o : sel_ledg ? io_ledg_o :
            sel_hlo ? io_hex_o[31:0] : sel_hhi ? io_hex_o[63:32] : sel_lcd ? io_lcd_o :
            sel_sw ? sw_sync[SYNC_STAGES-1] : sel_btn ? {28'd0, btn_sync[SYNC_STAGES-1]} : '0;
    valid   = (sel_dmem || sel_ledr || sel_ledg || sel_hlo || sel_hhi || sel_lcd || sel_sw || sel_btn) && !bus.misalign;
    shifted = rdata >> {off, 3'b000};
    bus.ld_data = !valid ? '0 :
                  bus.byte_num == SZ_BYTE ? {{24{!bus.ld_unsigned && shifted[7]}}, shifted[7:0]} :
                  bus.byte_num == SZ_HALF ? {{16{!bus.ld_unsigned && shifted[15]}}, shifted[15:0]} :
                  shifted;
  end
endmodule

// File: tb/tb_lsu.sv
// tb_lsu: scoreboard-driven self-checking bench for the load-store unit
module tb_lsu;
  import lsu_pkg::*;
  typedef struct { string tag; logic [31:0] v; } exp_t;
  logic clk = 0, rst_n = 0;
  logic [31:0] io_sw = '0, ledr, ledg, lcd;
  logic [3:0]  io_btn = '0;
  logic [63:0] hex;
  int n_tests = 0, n_fail = 0;
  exp_t exp_q[$];
  lsu_if bus();
  lsu dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .io_sw_i(io_sw), .io_btn_i(io_btn),
    .io_ledr_o(ledr), .io_ledg_o(ledg), .io_hex_o(hex), .io_lcd_o(lcd)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] n, input logic u, input logic en);
    bus.addr = a; bus.st_data = d; bus.byte_num = n; bus.ld_unsigned = u; bus.st_en = en;
  endtask
  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check(e.tag, bus.ld_data, e.v);
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [3:0] n);
    @(negedge clk);
    drive(a, d, n, 0, 1);
    @(posedge clk);
    #1 bus.st_en = 0;
  endtask
  task automatic ld(input string tag, input logic [31:0] a, input logic [3:0] n, input logic u, input logic [31:0] exp);
    @(negedge clk);
    drive(a, 32'h0, n, u, 0);
    exp_q.push_back('{tag, exp});
    #1 pop_check();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    drive(32'h2000, 0, SZ_WORD, 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_ledr", ledr, 0);
    check("rst_hex", hex, 0);
    rst_n = 1;
    bus.st_en = 0;
    st(32'h2000, 32'hDEADBEEF, SZ_WORD);
    ld("lw", 32'h2000, SZ_WORD, 0, 32'hDEADBEEF);
    ld("lb", 32'h2003, SZ_BYTE, 0, 32'hFFFFFFDE);
    ld("lbu", 32'h2003, SZ_BYTE, 1, 32'h000000DE);
    ld("lh", 32'h2002, SZ_HALF, 0, 32'hFFFFDEAD);
    ld("lhu", 32'h2000, SZ_HALF, 1, 32'h0000BEEF);
    @(negedge clk);
    drive(32'h2001, 32'h55, SZ_BYTE, 0, 1);
    exp_q.push_back('{"sb_prewrite", 32'hFFFFFFBE});
    #1 pop_check();
    @(posedge clk);
    #1 bus.st_en = 0;
    ld("sb_merge", 32'h2000, SZ_WORD, 0, 32'hDEAD55EF);
    st(32'h2002, 32'h1234, SZ_HALF);
    ld("sh_merge", 32'h2000, SZ_WORD, 0, 32'h123455EF);
    @(negedge clk);
    drive(32'h2002, 32'hFFFFFFFF, SZ_WORD, 0, 1);
    #1 check("misalign_sw", bus.misalign, 1);
    @(posedge clk);
    #1 bus.st_en = 0;
    ld("misalign_nochg", 32'h2000, SZ_WORD, 0, 32'h123455EF);
    ld("lw_misalign", 32'h2002, SZ_WORD, 0, 32'h0);
    ld("lh_misalign", 32'h2001, SZ_HALF, 0, 32'h0);
    @(negedge clk);
    drive(32'h2000, 0, 4'b0101, 0, 0);
    #1 check("bad_size", bus.misalign, 1);
    drive(32'h2000, 0, SZ_WORD, 0, 0);
    #1 check("aligned_word", bus.misalign, 0);
    st(32'h7000, 32'h3FF, SZ_WORD);
    check("ledr", ledr, 32'h3FF);
    ld("ld_ledr", 32'h7000, SZ_WORD, 0, 32'h3FF);
    st(32'h7025, 32'h79, SZ_BYTE);
    check("hex_byte5", hex, 64'h0000_7900_0000_0000);
    st(32'h7030, 32'hABCD, SZ_WORD);
    ld("ld_lcd", 32'h7030, SZ_WORD, 0, 32'hABCD);
    st(32'h7800, 32'hFFFFFFFF, SZ_WORD);
    ld("sw_ro", 32'h7800, SZ_WORD, 0, 32'h0);
    st(32'h0012_2000, 32'hCAFEF00D, SZ_WORD);
    ld("unmapped_ld", 32'h0012_2000, SZ_WORD, 0, 32'h0);
    ld("unmapped_nochg", 32'h2000, SZ_WORD, 0, 32'h123455EF);
    @(negedge clk);
    drive(32'h7800, 0, SZ_WORD, 0, 0);
    io_sw = 32'hA5;
    io_btn = 4'h9;
    #1 check("sync_before_n", bus.ld_data, 0);
    @(posedge clk);
    #1 check("sync_after_n", bus.ld_data, 0);
    @(posedge clk);
    #1 check("sync_after_n1", bus.ld_data, 32'hA5);
    ld("btn", 32'h7810, SZ_WORD, 0, 32'h9);
    @(negedge clk);
    rst_n = 0;
    drive(32'h7010, 32'h1234, SZ_WORD, 0, 1);
    @(posedge clk);
    #1 begin
      rst_n = 1;
      bus.st_en = 0;
      bus.addr = 32'h7800;
    end
    #1 check("rst_sw_sync", bus.ld_data, 0);
    check("rst_ledr_mid", ledr, 0);
    check("rst_ledg_drop", ledg, 0);
    check("rst_hex_mid", hex, 0);
    check("rst_lcd_mid", lcd, 0);
    ld("rst_dmem_keep", 32'h2000, SZ_WORD, 0, 32'h123455EF);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
